// File: rtl/nn_layer_seq.sv
// nn_layer_seq: time-multiplexed fully-connected layer. One shared signed MAC
// evaluates N_OUT neurons over N_IN inputs, one product per clock, followed
// by a PLAN sigmoid or saturating linear activation per neuron.
//
// Handshake: start is accepted only in IDLE (cycle 0). busy is high from the
// cycle after acceptance through the DONE cycle; done pulses for one cycle
// and y is valid (and has just been updated) in that same cycle. x and
// act_mode are captured at acceptance; w and bias must stay stable while busy.
module nn_layer_seq #(
  parameter int N_IN   = 7,
  parameter int N_OUT  = 13,
  parameter int X_W    = 17,
  parameter int X_FRAC = 16,
  parameter int W_W    = 17,
  parameter int W_FRAC = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       act_mode,
  input  logic [N_IN*X_W-1:0]        x,
  input  logic [N_OUT*N_IN*W_W-1:0]  w,
  input  logic [N_OUT*W_W-1:0]       bias,
  output logic                       busy,
  output logic                       done,
  output logic [N_OUT*X_W-1:0]       y,
  output logic [2:0]                 dbg_state
);

  localparam int P_W   = X_W + W_W;
  localparam int ACC_W = X_W + W_W + $clog2(N_IN + 1);
  localparam int F     = X_FRAC + W_FRAC;
  // Sigmoid segments are evaluated exactly with 5 extra fractional bits so
  // the /4, /8 and /32 slopes lose nothing before the final truncation.
  localparam int SW    = ACC_W + 6;
  localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  // Constants in F fractional bits (thresholds) or F+5 fractional bits (values).
  localparam logic [SW-1:0] TH_ONE   = SW'(1)  << F;   // |z| = 1
  localparam logic [SW-1:0] TH_FIVE  = SW'(5)  << F;   // |z| = 5
  localparam logic [SW-1:0] TH_19    = SW'(19) << F;   // 8*|z| = 19 <=> |z| = 2.375
  localparam logic [SW-1:0] V_ONE    = SW'(32) << F;   // 1.0
  localparam logic [SW-1:0] V_C1     = SW'(16) << F;   // 0.5
  localparam logic [SW-1:0] V_C2     = SW'(20) << F;   // 0.625
  localparam logic [SW-1:0] V_C3     = SW'(27) << F;   // 0.84375
  localparam logic [SW-1:0] SIG_MAX  = (SW'(1) << X_FRAC) - SW'(1);
  localparam logic signed [ACC_W-1:0] LIN_MAX = {{(ACC_W-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LIN_MIN = {{(ACC_W-X_W+1){1'b1}}, {(X_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_ACT, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             i_q, i_d;
  logic [JW-1:0]             j_q, j_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [N_IN*X_W-1:0]       x_q, x_d;
  logic                      mode_q, mode_d;
  logic [X_W-1:0]            ybuf_q [N_OUT];
  logic [X_W-1:0]            ybuf_d [N_OUT];
  logic [X_W-1:0]            y_q    [N_OUT];
  logic [X_W-1:0]            y_d    [N_OUT];

  logic signed [X_W-1:0]     x_arr    [N_IN];
  logic signed [W_W-1:0]     w_arr    [N_OUT][N_IN];
  logic signed [W_W-1:0]     bias_arr [N_OUT];

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
    assign x_arr[gi] = x_q[gi*X_W +: X_W];
  end

  for (genvar gj = 0; gj < N_OUT; gj++) begin : g_neuron
    assign bias_arr[gj]        = bias[gj*W_W +: W_W];
    assign y[gj*X_W +: X_W]    = y_q[gj];
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_w
      assign w_arr[gj][gi] = w[(gj*N_IN+gi)*W_W +: W_W];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  logic signed [P_W-1:0]   prod;
  logic [ACC_W-1:0]        prod_ext;
  logic [ACC_W-1:0]        bias_ext;
  logic [ACC_W-1:0]        abs_z;
  logic [SW-1:0]           a_ext;
  logic [SW-1:0]           sig_v;
  logic [SW-1:0]           sig_sh;
  logic [X_W-1:0]          sig_y;
  logic signed [ACC_W-1:0] lin_sh;
  logic [X_W-1:0]          lin_y;
  logic [X_W-1:0]          act_y;

  // Datapath: MAC product, bias alignment and both activation functions of acc_q.
  always_comb begin
    prod     = x_arr[i_q] * w_arr[j_q][i_q];
    prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    bias_ext = {{(ACC_W-W_W){bias_arr[j_q][W_W-1]}}, bias_arr[j_q]} << X_FRAC;

    abs_z = acc_q[ACC_W-1] ? $unsigned(-acc_q) : $unsigned(acc_q);
    a_ext = {6'b0, abs_z};
    if (a_ext >= TH_FIVE) begin
      sig_v = V_ONE;
    end else if ((a_ext << 3) >= TH_19) begin
      sig_v = a_ext + V_C3;
    end else if (a_ext >= TH_ONE) begin
      sig_v = (a_ext << 2) + V_C2;
    end else begin
      sig_v = (a_ext << 3) + V_C1;
    end
    if (acc_q[ACC_W-1]) begin
      sig_v = V_ONE - sig_v;
    end
    sig_sh = sig_v >> (W_FRAC + 5);
    sig_y  = (sig_sh > SIG_MAX) ? SIG_MAX[X_W-1:0] : sig_sh[X_W-1:0];

    lin_sh = acc_q >>> W_FRAC;
    if (lin_sh > LIN_MAX) begin
      lin_y = LIN_MAX[X_W-1:0];
    end else if (lin_sh < LIN_MIN) begin
      lin_y = LIN_MIN[X_W-1:0];
    end else begin
      lin_y = lin_sh[X_W-1:0];
    end

    act_y = mode_q ? lin_y : sig_y;
  end

  // Next-state and register update logic for the sequencer.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    x_d     = x_q;
    mode_d  = mode_q;
    ybuf_d  = ybuf_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x;
          mode_d  = act_mode;
          j_d     = '0;
          state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        acc_d   = bias_ext;
        i_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        if (i_q == IW'(N_IN - 1)) begin
          state_d = S_ACT;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_ACT: begin
        ybuf_d[j_q] = act_y;
        if (j_q == JW'(N_OUT - 1)) begin
          // Load y on entry to DONE so it is already updated while done is high.
          y_d     = ybuf_d;
          state_d = S_DONE;
        end else begin
          j_d     = j_q + JW'(1);
          state_d = S_BIAS;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      mode_q  <= 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        ybuf_q[k] <= '0;
        y_q[k]    <= '0;
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      ybuf_q  <= ybuf_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Testbench for nn_layer_seq: directed timing/handshake/activation checks on a
// default-size instance plus randomized runs on default and 2x3 instances
// against a real-arithmetic reference of the layer equations.
module tb_nn_layer_seq;

  localparam int XW  = 17;
  localparam int WW  = 17;
  localparam int NI  = 7;
  localparam int NO  = 13;
  localparam int SNI = 2;
  localparam int SNO = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default-size instance
  logic                  start, act_mode;
  logic [NI*XW-1:0]      x;
  logic [NO*NI*WW-1:0]   w;
  logic [NO*WW-1:0]      bias;
  logic                  busy, done;
  logic [NO*XW-1:0]      y;
  logic [2:0]            dbg_state;

  // small instance
  logic                  s_start, s_mode;
  logic [SNI*XW-1:0]     s_x;
  logic [SNO*SNI*WW-1:0] s_w;
  logic [SNO*WW-1:0]     s_bias;
  logic                  s_busy, s_done;
  logic [SNO*XW-1:0]     s_y;
  logic [2:0]            s_dbg_state;

  nn_layer_seq dut (
    .clk(clk), .rst(rst), .start(start), .act_mode(act_mode), .x(x), .w(w),
    .bias(bias), .busy(busy), .done(done), .y(y), .dbg_state(dbg_state)
  );

  nn_layer_seq #(.N_IN(SNI), .N_OUT(SNO)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .act_mode(s_mode), .x(s_x), .w(s_w),
    .bias(s_bias), .busy(s_busy), .done(s_done), .y(s_y), .dbg_state(s_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [XW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Layer output for one neuron from its exact accumulator value (28 frac bits).
  function automatic logic [XW-1:0] ref_out(input bit mode, input longint acc);
    real z, a, f;
    longint r;
    if (mode) begin
      r = acc >>> 12;
      if (r > 65535) r = 65535;
      if (r < -65536) r = -65536;
    end else begin
      z = real'(acc) / (2.0 ** 28);
      a = (z < 0.0) ? -z : z;
      if (a >= 5.0)        f = 1.0;
      else if (a >= 2.375) f = a / 32.0 + 0.84375;
      else if (a >= 1.0)   f = a / 8.0 + 0.625;
      else                 f = a / 4.0 + 0.5;
      if (z < 0.0) f = 1.0 - f;
      r = longint'($floor(f * 65536.0));
      if (r > 65535) r = 65535;
      if (r < 0) r = 0;
    end
    return r[XW-1:0];
  endfunction

  function automatic logic signed [XW-1:0] rnd_s();
    int k, m;
    k = $urandom_range(16, 1);
    m = $urandom_range((1 << k) - 1, 0);
    if ($urandom_range(1, 0) == 1) m = -m;
    return m[XW-1:0];
  endfunction

  logic signed [XW-1:0] xv [NI];
  logic signed [WW-1:0] wv [NO][NI];
  logic signed [WW-1:0] bv [NO];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int            done_cnt;
  int            done_at [4];
  logic [NO*XW-1:0] y_first;
  bit            busy_tr [0:300];

  // Caller sits in cycle 0 with operands driven; start is raised here for cycle 0.
  task automatic run_big(input int ncyc, input bit hold, input int p1, input int p2);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) done_at[k] = -1;
    start = 1'b1;
    busy_tr[0] = busy;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      start = hold || (c == p1) || (c == p2);
      busy_tr[c] = busy;
      if (done) begin
        if (done_cnt < 4) done_at[done_cnt] = c;
        if (done_cnt == 0) y_first = y;
        done_cnt++;
      end
    end
    start = 1'b0;
  endtask

  task automatic set_uniform(input logic [WW-1:0] b0, input logic [WW-1:0] w0,
                             input logic [XW-1:0] x0, input bit m);
    x = '0;
    w = '0;
    act_mode = m;
    x[XW-1:0] = x0;
    for (int j = 0; j < NO; j++) begin
      bias[j*WW +: WW]     = b0;
      w[(j*NI)*WW +: WW]   = w0;
    end
  endtask

  task automatic check_y_big(input string tag);
    logic [XW-1:0] e;
    for (int j = 0; j < NO; j++) begin
      e = exp_q.pop_front();
      check(tag, y_first[j*XW +: XW], e);
    end
  endtask

  task automatic expect_uniform(input logic [XW-1:0] e);
    exp_q.delete();
    for (int j = 0; j < NO; j++) exp_q.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, c;
    bit got;
    longint acc;

    rst = 1'b1; start = 1'b0; act_mode = 1'b0; x = '0; w = '0; bias = '0;
    s_start = 1'b0; s_mode = 1'b0; s_x = '0; s_w = '0; s_bias = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_y", |y, 0);

    // zero weights/bias: sigmoid(0) = 0.5, timing of busy/done
    set_uniform(17'h00000, 17'h00000, 17'h00000, 1'b0);
    run_big(125, 1'b0, -1, -1);
    check("t0_done_cnt", done_cnt, 1);
    check("t0_done_at", done_at[0], 118);
    check("t0_busy_c0", busy_tr[0], 0);
    check("t0_busy_c1", busy_tr[1], 1);
    check("t0_busy_c118", busy_tr[118], 1);
    check("t0_busy_c119", busy_tr[119], 0);
    expect_uniform(17'h08000);
    check_y_big("t0_y");
    check("t0_y_held", y[XW-1:0], 17'h08000);

    // sigmoid with bias only
    set_uniform(17'h01000, 17'h00000, 17'h00000, 1'b0);
    run_big(125, 1'b0, -1, -1);
    expect_uniform(17'h0C000);
    check_y_big("sig_p1");
    set_uniform(17'h1F000, 17'h00000, 17'h00000, 1'b0);
    run_big(125, 1'b0, -1, -1);
    expect_uniform(17'h04000);
    check_y_big("sig_m1");
    set_uniform(17'h07000, 17'h00000, 17'h00000, 1'b0);
    run_big(125, 1'b0, -1, -1);
    expect_uniform(17'h0FFFF);
    check_y_big("sig_p7");

    // linear mode
    set_uniform(17'h00000, 17'h00800, 17'h08000, 1'b1);
    run_big(125, 1'b0, -1, -1);
    expect_uniform(17'h04000);
    check_y_big("lin_half");
    set_uniform(17'h00000, 17'h02000, 17'h08000, 1'b1);
    run_big(125, 1'b0, -1, -1);
    expect_uniform(17'h0FFFF);
    check_y_big("lin_sat_hi");
    set_uniform(17'h00000, 17'h1E000, 17'h08000, 1'b1);
    run_big(125, 1'b0, -1, -1);
    expect_uniform(17'h10000);
    check_y_big("lin_neg");

    // extra start pulses while busy are ignored
    set_uniform(17'h01000, 17'h00000, 17'h00000, 1'b0);
    run_big(125, 1'b0, 5, 60);
    check("hs_done_cnt", done_cnt, 1);
    check("hs_done_at", done_at[0], 118);
    check("hs_y0", y_first[XW-1:0], 17'h0C000);

    // reset in the middle of a run
    set_uniform(17'h1F000, 17'h00000, 17'h00000, 1'b0);
    start = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_y", |y, 0);
    n = 0;
    for (int k = 0; k < 130; k++) begin
      step();
      if (done || busy) n++;
    end
    check("mid_quiet", n, 0);
    run_big(125, 1'b0, -1, -1);
    check("mid_rerun_at", done_at[0], 118);
    expect_uniform(17'h04000);
    check_y_big("mid_rerun_y");

    // rst and start together: rst wins
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    n = 0;
    for (int k = 0; k < 130; k++) begin
      if (done || busy) n++;
      step();
    end
    check("rst_start", n, 0);

    // start held high: back-to-back runs
    run_big(240, 1'b1, -1, -1);
    check("hold_cnt", done_cnt, 2);
    check("hold_at0", done_at[0], 118);
    check("hold_at1", done_at[1], 237);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // randomized default-size runs
    for (int r = 0; r < 4; r++) begin
      act_mode = r[0];
      for (int i = 0; i < NI; i++) begin
        xv[i] = rnd_s();
        x[i*XW +: XW] = xv[i];
      end
      for (int j = 0; j < NO; j++) begin
        bv[j] = rnd_s();
        bias[j*WW +: WW] = bv[j];
        for (int i = 0; i < NI; i++) begin
          wv[j][i] = rnd_s();
          w[(j*NI+i)*WW +: WW] = wv[j][i];
        end
      end
      exp_q.delete();
      for (int j = 0; j < NO; j++) begin
        acc = longint'(bv[j]) * 65536;
        for (int i = 0; i < NI; i++) acc += longint'(xv[i]) * longint'(wv[j][i]);
        exp_q.push_back(ref_out(act_mode, acc));
      end
      run_big(125, 1'b0, -1, -1);
      check("rnd_big_at", done_at[0], 118);
      check_y_big("rnd_big_y");
    end

    // randomized 2-input / 3-neuron runs
    for (int r = 0; r < 1000; r++) begin
      s_mode = 1'($urandom_range(1, 0));
      for (int i = 0; i < SNI; i++) begin
        xv[i] = rnd_s();
        s_x[i*XW +: XW] = xv[i];
      end
      exp_q.delete();
      for (int j = 0; j < SNO; j++) begin
        bv[j] = rnd_s();
        s_bias[j*WW +: WW] = bv[j];
        acc = longint'(bv[j]) * 65536;
        for (int i = 0; i < SNI; i++) begin
          wv[j][i] = rnd_s();
          s_w[(j*SNI+i)*WW +: WW] = wv[j][i];
          acc += longint'(xv[i]) * longint'(wv[j][i]);
        end
        exp_q.push_back(ref_out(s_mode, acc));
      end
      s_start = 1'b1;
      c = 0;
      got = 1'b0;
      while (!got && c < 30) begin
        step();
        c++;
        s_start = 1'b0;
        if (s_done) got = 1'b1;
      end
      check("s_done_at", c, 13);
      for (int j = 0; j < SNO; j++) begin
        check("s_y", s_y[j*XW +: XW], exp_q.pop_front());
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_layer_seq.md
# nn_layer_seq

Parametrised, time-multiplexed fully-connected neural layer: one shared multiply-accumulate unit computes N_OUT neurons over N_IN inputs, one product per clock. It follows the fixed 7-input / 13-neuron combinational neuron arrays and replaces them. It adds:
- run-time selectable activation (PLAN sigmoid or saturating linear);
- a start/busy/done handshake;
- synchronous reset.

Layers are chained by feeding one instance's `y` into the next instance's `x`.

## Interface
Parameters:
- N_IN, 7, inputs per neuron (≥1)
- N_OUT, 13, neurons in the layer (≥1)
- X_W, 17, activation width, signed two's complement, X_FRAC fractional bits (s16f)
- X_FRAC, 16, activation fractional bits
- W_W, 17, weight/bias width, signed two's complement, W_FRAC fractional bits (s4i12f)
- W_FRAC, 12, weight/bias fractional bits

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request one layer evaluation
- act_mode  in  1  0 = PLAN sigmoid, 1 = saturating linear; sampled at accepted start
- x  in  N_IN*X_W  inputs; input i at [i*X_W +: X_W]; latched at accepted start
- w  in  N_OUT*N_IN*W_W  weights; neuron j, input i at [(j*N_IN+i)*W_W +: W_W]; must be stable while busy
- bias  in  N_OUT*W_W  biases; neuron j at [j*W_W +: W_W]; must be stable while busy
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse; y valid and updated in this cycle
- y  out  N_OUT*X_W  outputs; neuron j at [j*X_W +: X_W]; held between done pulses

## Operation
- FSM states: IDLE, BIAS, MAC, ACT, DONE.
- IDLE: when start=1, latch x and act_mode, set j=0, go to BIAS. start in any other state is ignored.
- BIAS: acc ← sign-extended bias[j] << X_FRAC. Go to MAC with i=0.
- MAC: acc ← acc + x[i]·w[j][i], full signed product (X_W+W_W bits, X_FRAC+W_FRAC fractional bits). i increments each cycle; after i=N_IN−1, go to ACT.
- ACT: ybuf[j] ← f(acc). If j=N_OUT−1, go to DONE; else j++ and go to BIAS.
- DONE: y ← ybuf, done=1, then IDLE.
- Accumulator width: X_W+W_W+clog2(N_IN+1). No internal overflow is possible.
- Let z = acc, with F = X_FRAC+W_FRAC fractional bits.
- Sigmoid mode (PLAN), computed on |z|:
  - |z| ≥ 5 → 1
  - 2.375 ≤ |z| < 5 → |z|/32 + 0.84375
  - 1 ≤ |z| < 2.375 → |z|/8 + 0.625
  - |z| < 1 → |z|/4 + 0.5
  - For z < 0, result = 1 − f(|z|).
  - Truncate to X_FRAC bits, then clamp to [0, 2^X_FRAC − 1]. 1.0 becomes 0x0FFFF at default widths.
- Linear mode: z arithmetic-shifted right by W_FRAC (truncation toward −∞), then saturated to the signed X_W range.
- Reset values: state IDLE, busy=0, done=0, y=0, all internal registers 0.

## Timing
- The cycle in which start=1 is sampled in IDLE is cycle 0.
- Each neuron takes N_IN+2 cycles.
- done is high in cycle N_OUT·(N_IN+2)+1, which is 118 at default parameters.
- busy is high in cycles 1 … N_OUT·(N_IN+2)+1 and low in the cycle after done.
- start held high continuously: a new run is accepted in the cycle after DONE, so runs are back-to-back with one IDLE cycle between them.
- y changes only in the DONE cycle.
- rst=1 in any cycle, including mid-run: next cycle is IDLE with busy=0, done=0, y=0. The partial run is discarded and no done pulse is produced.
- rst and start both high: rst wins and the start is not accepted.

## Test plan
- Reset: bias=0, all w=0, act_mode=0, pulse start → every y[j]=0x08000 (0.5); done exactly in cycle 118; busy low before the start and after done.
- Sigmoid values, w=0, act_mode=0:
  - all bias=0x01000 (+1.0) → y=0x0C000
  - all bias=0x1F000 (−1.0) → y=0x04000
  - all bias=0x07000 (+7.0) → y=0x0FFFF
- Linear mode, act_mode=1, bias=0, x[0]=0x08000 (0.5), other x=0:
  - w[j][0]=0x00800 (0.5) → y=0x04000
  - w[j][0]=0x02000 (2.0) → y=0x0FFFF (saturated)
  - w[j][0]=0x1E000 (−2.0) → y=0x10000 (−1.0)
- Handshake: start pulsed again at cycles 5 and 60 → ignored, exactly one done at cycle 118. start held high → done pulses at cycles 118 and 237.
- Reset mid-run: rst at cycle 50 → y=0, busy=0, no done. A fresh start then completes normally with the correct values.
- Parametrisation: N_IN=2, N_OUT=3, random x/w/bias, both modes → done at cycle 13; y matches a bit-exact reference model in 1000 random runs.
